rc4_decrypt_core: RTL and testbench
===================================

# rc4_decrypt_core

Consumer of the shuffled S array: once the key-schedule shuffle has permuted S, this block runs the RC4 pseudo-random generation loop and produces the keystream. It XORs each keystream byte with the encrypted-message ROM and writes plaintext to the decrypted-message RAM. It swaps S entries as it goes and asserts `msg_valid` only if every output byte is lowercase `a`–`z` or space. It aborts early on the first invalid byte, which lets the key-search controller reject keys quickly.

## Interface
- `MSG_LEN`, 32: number of message bytes processed.
- `MSG_AW`, 5: address width of the message ROM and RAM; `MSG_LEN` ≤ 2^`MSG_AW`.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  level request, sampled only in IDLE.
- `s_addr`  out  8  S RAM address.
- `s_rdata`  in  8  S RAM read data.
- `s_wdata`  out  8  S RAM write data.
- `s_wren`  out  1  S RAM write enable.
- `rom_addr`  out  `MSG_AW`  encrypted ROM address.
- `rom_rdata`  in  8  encrypted ROM data.
- `dec_addr`  out  `MSG_AW`  decrypted RAM address.
- `dec_wdata`  out  8  decrypted RAM write data.
- `dec_wren`  out  1  decrypted RAM write enable.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high in DONE.
- `msg_valid`  out  1  result flag, meaningful while `done` is high.

## Operation
- Memories are synchronous-read with 1-cycle latency. An address driven during state X is captured at the end of X; its data is valid and sampled in state X+1.
- All memory outputs are decoded only from the registered state and the datapath registers, `i`, `j`, `k`, `si`, `sj`, `f`, `enc`. Registers `i` and `j` are 8 bits; `k` is `MSG_AW` bits. All sums are mod 256.
- IDLE: `i`, `j` and `k` are held at 0; the internal valid flag is set to 1. When `start`=1, go to INC_I.
- Per-byte loop, 10 states, one cycle each:
  - INC_I: `i` ← `i`+1.
  - RD_SI: `s_addr`=`i`, `rom_addr`=`k`.
  - CAP_SI: `si` ← `s_rdata`, `enc` ← `rom_rdata`, `j` ← `j`+`s_rdata`.
  - RD_SJ: `s_addr`=`j`.
  - CAP_SJ: `sj` ← `s_rdata`.
  - WR_SI: `s_addr`=`i`, `s_wdata`=`sj`, `s_wren`=1.
  - WR_SJ: `s_addr`=`j`, `s_wdata`=`si`, `s_wren`=1.
  - RD_F: `s_addr`=`si`+`sj`.
  - CAP_F: `f` ← `s_rdata`.
  - WR_DEC: `dec_addr`=`k`, `dec_wdata`=`f`^`enc`, `dec_wren`=1.
- After WR_DEC:
  - If the byte is outside 0x61–0x7A and is not 0x20: clear the valid flag and go to DONE (early abort).
  - Else if `k`=`MSG_LEN`−1: go to DONE.
  - Else: `k` ← `k`+1 and go to INC_I.
- DONE: `done`=1 and `msg_valid`=valid flag. When `start`=0, return to IDLE. While `start` stays high, remain in DONE (no auto-restart).
- When `i`=`j`, the two writes store the same value, which is correct RC4 behaviour and needs no special case.
- RD_F reads S after both swap writes have completed, so it sees the updated array.
- In any state other than IDLE, `start` is ignored.

## Timing
- Reset values: state=IDLE; all outputs 0, including `s_addr`, `s_wdata`, `s_wren`, `rom_addr`, `dec_addr`, `dec_wdata`, `dec_wren`, `busy`, `done` and `msg_valid`; all datapath registers 0.
- Reset mid-operation returns to IDLE immediately. S RAM and decrypted RAM keep any partial writes; the caller must re-run the shuffle before restarting.
- Write enables are high for exactly one cycle per write. There are 2 S writes and 1 decrypted write per byte.
- `start` sampled at edge E0 means `done` rises after edge E0+10·N, where N is the number of bytes processed (`MSG_LEN` on success, or the index of the aborting byte +1).
- `msg_valid` is 0 outside DONE.

## Test plan
- S preloaded with the shuffle of key 0x4B6579, `MSG_LEN`=9, ROM=9B F3 16 E8 D9 40 AF 0A D3 → decrypted RAM=70 6C 61 69 6E 74 65 78 74 ("plaintext"); `msg_valid`=1; `done` exactly 90 cycles after start is sampled; S equals the reference model after 9 swaps.
- Same S, ROM=BB F3 16 E8 D9 40 AF 0A D3 → dec[0]=0x50 ('P'); abort with only 1 `dec_wren` pulse; `done` after 10 cycles; `msg_valid`=0.
- Identity S (S[x]=x), ROM[0]=0x72 → byte 0: `i`=1, `j`=1, S unchanged, f=0x02, dec[0]=0x70.
- Reset asserted in CAP_SJ of byte 3 → all outputs 0 the same cycle, no further writes; then re-shuffle and restart → same result as scenario 1.
- `start` held high through DONE for 20 cycles → no restart and `done` stays 1. Drop `start` → IDLE. Pulse `start` during `busy` → no effect on cycle count.
- Check every cycle: `s_wren` and `dec_wren` never both high; `s_addr` on RD_F equals `si`+`sj` mod 256, including the wrap case `si`=0xF0, `sj`=0x20 → address 0x10.

Source files
------------

// File: rtl/rc4_decrypt_core.sv
// RC4 keystream generator and message decryptor: walks the shuffled S array,
// swaps entries, XORs keystream with the encrypted ROM and flags non-text output.
module rc4_decrypt_core #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [7:0]        s_addr,
  input  logic [7:0]        s_rdata,
  output logic [7:0]        s_wdata,
  output logic              s_wren,
  output logic [MSG_AW-1:0] rom_addr,
  input  logic [7:0]        rom_rdata,
  output logic [MSG_AW-1:0] dec_addr,
  output logic [7:0]        dec_wdata,
  output logic              dec_wren,
  output logic              busy,
  output logic              done,
  output logic              msg_valid
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_INC_I, ST_RD_SI, ST_CAP_SI, ST_RD_SJ, ST_CAP_SJ,
    ST_WR_SI, ST_WR_SJ, ST_RD_F, ST_CAP_F, ST_WR_DEC, ST_DONE
  } state_t;

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);
  localparam logic [MSG_AW-1:0] K_ONE  = {{(MSG_AW-1){1'b0}}, 1'b1};

  state_t            state_r, state_nxt_s;
  logic [7:0]        i_r, j_r, si_r, sj_r, f_r, enc_r;
  logic [7:0]        i_nxt_s, j_nxt_s, si_nxt_s, sj_nxt_s, f_nxt_s, enc_nxt_s;
  logic [MSG_AW-1:0] k_r, k_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic [7:0]        dec_byte_s;

  // Accept only lowercase letters and space as plausible plaintext.
  function automatic logic byte_is_text(input logic [7:0] b);
    byte_is_text = (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
  endfunction

  assign dec_byte_s = f_r ^ enc_r;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      i_r     <= 8'h00;
      j_r     <= 8'h00;
      k_r     <= {MSG_AW{1'b0}};
      si_r    <= 8'h00;
      sj_r    <= 8'h00;
      f_r     <= 8'h00;
      enc_r   <= 8'h00;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      i_r     <= i_nxt_s;
      j_r     <= j_nxt_s;
      k_r     <= k_nxt_s;
      si_r    <= si_nxt_s;
      sj_r    <= sj_nxt_s;
      f_r     <= f_nxt_s;
      enc_r   <= enc_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  // Next-state, datapath updates and memory port decode from the registered state.
  always_comb begin
    state_nxt_s = state_r;
    i_nxt_s     = i_r;
    j_nxt_s     = j_r;
    k_nxt_s     = k_r;
    si_nxt_s    = si_r;
    sj_nxt_s    = sj_r;
    f_nxt_s     = f_r;
    enc_nxt_s   = enc_r;
    valid_nxt_s = valid_r;
    s_addr      = 8'h00;
    s_wdata     = 8'h00;
    s_wren      = 1'b0;
    rom_addr    = {MSG_AW{1'b0}};
    dec_addr    = {MSG_AW{1'b0}};
    dec_wdata   = 8'h00;
    dec_wren    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    msg_valid   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy        = 1'b0;
        i_nxt_s     = 8'h00;
        j_nxt_s     = 8'h00;
        k_nxt_s     = {MSG_AW{1'b0}};
        valid_nxt_s = 1'b1;
        if (start) state_nxt_s = ST_INC_I;
        else       state_nxt_s = ST_IDLE;
      end
      ST_INC_I: begin
        i_nxt_s     = i_r + 8'd1;
        state_nxt_s = ST_RD_SI;
      end
      ST_RD_SI: begin
        s_addr      = i_r;
        rom_addr    = k_r;
        state_nxt_s = ST_CAP_SI;
      end
      ST_CAP_SI: begin
        si_nxt_s    = s_rdata;
        enc_nxt_s   = rom_rdata;
        j_nxt_s     = j_r + s_rdata;
        state_nxt_s = ST_RD_SJ;
      end
      ST_RD_SJ: begin
        s_addr      = j_r;
        state_nxt_s = ST_CAP_SJ;
      end
      ST_CAP_SJ: begin
        sj_nxt_s    = s_rdata;
        state_nxt_s = ST_WR_SI;
      end
      ST_WR_SI: begin
        s_addr      = i_r;
        s_wdata     = sj_r;
        s_wren      = 1'b1;
        state_nxt_s = ST_WR_SJ;
      end
      ST_WR_SJ: begin
        s_addr      = j_r;
        s_wdata     = si_r;
        s_wren      = 1'b1;
        state_nxt_s = ST_RD_F;
      end
      ST_RD_F: begin
        s_addr      = si_r + sj_r;
        state_nxt_s = ST_CAP_F;
      end
      ST_CAP_F: begin
        f_nxt_s     = s_rdata;
        state_nxt_s = ST_WR_DEC;
      end
      ST_WR_DEC: begin
        dec_addr  = k_r;
        dec_wdata = dec_byte_s;
        dec_wren  = 1'b1;
        // Abort on the first non-text byte so bad keys are rejected early.
        if (!byte_is_text(dec_byte_s)) begin
          valid_nxt_s = 1'b0;
          state_nxt_s = ST_DONE;
        end else if (k_r == K_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          k_nxt_s     = k_r + K_ONE;
          state_nxt_s = ST_INC_I;
        end
      end
      ST_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        msg_valid = valid_r;
        if (!start) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_DONE;
      end
      default: begin
        busy        = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Directed bench for rc4_decrypt_core: behavioural S/ROM/decrypted memories,
// an independent RC4 reference model, and hand-computed expected bytes.
module tb_rc4_decrypt_core;

  localparam int MSG_LEN = 9;
  localparam int MSG_AW  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        s_addr, s_rdata, s_wdata;
  logic              s_wren;
  logic [MSG_AW-1:0] rom_addr, dec_addr;
  logic [7:0]        rom_rdata, dec_wdata;
  logic              dec_wren, busy, done, msg_valid;

  rc4_decrypt_core #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_addr(s_addr), .s_rdata(s_rdata), .s_wdata(s_wdata), .s_wren(s_wren),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_wren(dec_wren),
    .busy(busy), .done(done), .msg_valid(msg_valid)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem [256];
  logic [7:0] ld_s  [256];
  logic [7:0] ref_s [256];
  logic [7:0] rom_mem [32];
  logic [7:0] dec_mem [32];
  logic       ld_en;

  // Synchronous-read memories with one cycle of latency; ld_en reloads S and clears dec.
  always @(posedge clk) begin
    if (ld_en) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= ld_s[x];
      for (int x = 0; x < 32; x++) dec_mem[x] <= 8'h00;
    end else begin
      if (s_wren) s_mem[s_addr] <= s_wdata;
      if (dec_wren) dec_mem[dec_addr] <= dec_wdata;
    end
    s_rdata   <= s_mem[s_addr];
    rom_rdata <= rom_mem[rom_addr];
  end

  int swr_cnt = 0, dwr_cnt = 0, overlap_cnt = 0, rdf_bad = 0;
  logic [7:0] w_addr_q[$], w_data_q[$], rdf_q[$];
  logic       pend1 = 1'b0, pend2 = 1'b0;
  logic [7:0] w1d = 8'h00, w2d = 8'h00;

  // Per-cycle bus monitor: write counts, write exclusivity, and the RD_F address after each swap pair.
  always @(negedge clk) begin
    if (reset) begin
      pend1 <= 1'b0;
      pend2 <= 1'b0;
    end else begin
      if (s_wren && dec_wren) overlap_cnt <= overlap_cnt + 1;
      if (s_wren) begin
        swr_cnt <= swr_cnt + 1;
        w_addr_q.push_back(s_addr);
        w_data_q.push_back(s_wdata);
      end
      if (dec_wren) dwr_cnt <= dwr_cnt + 1;
      if (pend2) begin
        rdf_q.push_back(s_addr);
        if (s_addr !== 8'(w1d + w2d)) rdf_bad <= rdf_bad + 1;
      end
      pend1 <= s_wren && !pend1;
      pend2 <= s_wren && pend1;
      if (s_wren && !pend1) w1d <= s_wdata;
      if (s_wren && pend1) w2d <= s_wdata;
    end
  end

  int n_checks = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [63:0] out_bundle();
    return {25'd0, s_addr, s_wdata, s_wren, rom_addr, dec_addr, dec_wdata,
            dec_wren, busy, done, msg_valid};
  endfunction

  // Reference KSA for key "Key" (0x4B 0x65 0x79) into ref_s and ld_s.
  function automatic void ksa_fill();
    logic [7:0] key [3];
    logic [7:0] j, t;
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
    for (int x = 0; x < 256; x++) ref_s[x] = 8'(x);
    j = 8'h00;
    for (int x = 0; x < 256; x++) begin
      j = j + ref_s[x] + key[x % 3];
      t = ref_s[x]; ref_s[x] = ref_s[j]; ref_s[j] = t;
    end
    for (int x = 0; x < 256; x++) ld_s[x] = ref_s[x];
  endfunction

  function automatic void model_prga(input int n);
    logic [7:0] i, j, t;
    i = 8'h00; j = 8'h00;
    for (int b = 0; b < n; b++) begin
      i = i + 8'd1;
      j = j + ref_s[i];
      t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
    end
  endfunction

  task automatic do_load();
    ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic set_rom(input logic [7:0] b0);
    logic [7:0] tail [8];
    tail = '{8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int x = 0; x < 32; x++) rom_mem[x] = 8'h00;
    rom_mem[0] = b0;
    for (int x = 0; x < 8; x++) rom_mem[x+1] = tail[x];
  endtask

  // Start a run and count cycles from the sampling edge until done is seen (bounded).
  task automatic run_msg(input bit pulse, output int cycles);
    start = 1'b1;
    @(posedge clk); #1;
    if (pulse) start = 1'b0;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
      if (pulse && cycles == 30) start = 1'b1;
      else if (pulse && cycles == 31) start = 1'b0;
    end while (!done && cycles < 2000);
  endtask

  task automatic scen_plain(input bit pulse, input string tg);
    int cyc, bs, bd, bad, lows;
    logic [7:0] txt [9];
    txt = '{8'h70, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    ksa_fill();
    do_load();
    set_rom(8'h9B);
    bs = swr_cnt; bd = dwr_cnt;
    run_msg(pulse, cyc);
    check_eq({tg, "_cycles"}, 64'(cyc), 64'd90);
    check_eq({tg, "_done"}, 64'(done), 64'd1);
    check_eq({tg, "_valid"}, 64'(msg_valid), 64'd1);
    for (int b = 0; b < 9; b++) check_eq($sformatf("%s_dec%0d", tg, b), 64'(dec_mem[b]), 64'(txt[b]));
    model_prga(9);
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== ref_s[x]) bad++;
    check_eq({tg, "_s_array"}, 64'(bad), 64'd0);
    check_eq({tg, "_s_writes"}, 64'(swr_cnt - bs), 64'd18);
    check_eq({tg, "_dec_writes"}, 64'(dwr_cnt - bd), 64'd9);
    if (!pulse) begin
      lows = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (!done || busy) lows++;
      end
      check_eq({tg, "_hold_done"}, 64'(lows), 64'd0);
      start = 1'b0;
    end
    @(posedge clk); #1;
    check_eq({tg, "_back_idle"}, 64'({done, busy}), 64'd0);
  endtask

  initial begin
    int cyc, bs, bd, wb, rb;
    reset = 1'b1; start = 1'b0; ld_en = 1'b0;
    for (int x = 0; x < 32; x++) rom_mem[x] = 8'h00;
    #1;
    check_eq("reset_outputs", out_bundle(), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_outputs", out_bundle(), 64'd0);

    // "plaintext" with start held through DONE
    scen_plain(1'b0, "plain");

    // Early abort on 'P'
    ksa_fill(); do_load(); set_rom(8'hBB);
    bs = swr_cnt; bd = dwr_cnt;
    run_msg(1'b1, cyc);
    check_eq("abort_cycles", 64'(cyc), 64'd10);
    check_eq("abort_valid", 64'({done, msg_valid}), 64'b10);
    check_eq("abort_dec0", 64'(dec_mem[0]), 64'h50);
    check_eq("abort_dec_writes", 64'(dwr_cnt - bd), 64'd1);
    check_eq("abort_s_writes", 64'(swr_cnt - bs), 64'd2);
    @(posedge clk); #1;

    // Identity S: byte 0 swaps S[1] with itself, f=S[2]=2; byte 1 gives f=5 and aborts
    for (int x = 0; x < 256; x++) ld_s[x] = 8'(x);
    do_load();
    for (int x = 0; x < 32; x++) rom_mem[x] = 8'h00;
    rom_mem[0] = 8'h72;
    wb = w_addr_q.size(); bd = dwr_cnt;
    run_msg(1'b1, cyc);
    check_eq("ident_cycles", 64'(cyc), 64'd20);
    check_eq("ident_dec0", 64'(dec_mem[0]), 64'h70);
    check_eq("ident_wr0", 64'({w_addr_q[wb], w_data_q[wb]}), 64'h0101);
    check_eq("ident_wr1", 64'({w_addr_q[wb+1], w_data_q[wb+1]}), 64'h0101);
    check_eq("ident_valid", 64'(msg_valid), 64'd0);
    check_eq("ident_dec_writes", 64'(dwr_cnt - bd), 64'd2);
    @(posedge clk); #1;

    // Wrap: si=0xF0, sj=0x20 so RD_F addresses 0x10
    for (int x = 0; x < 256; x++) ld_s[x] = 8'(x);
    ld_s[1] = 8'hF0; ld_s[8'hF0] = 8'h20; ld_s[8'h20] = 8'h01;
    do_load();
    rom_mem[0] = 8'h71;
    rb = rdf_q.size();
    run_msg(1'b1, cyc);
    check_eq("wrap_rdf_addr", 64'(rdf_q[rb]), 64'h10);
    check_eq("wrap_dec0", 64'(dec_mem[0]), 64'h61);
    check_eq("wrap_cycles", 64'(cyc), 64'd20);
    @(posedge clk); #1;

    // Reset in CAP_SJ of byte 3, then re-shuffle and rerun with a stray start pulse
    ksa_fill(); do_load(); set_rom(8'h9B);
    bd = dwr_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (34) @(posedge clk);
    #1;
    check_eq("mid_busy", 64'(busy), 64'd1);
    check_eq("mid_dec_writes", 64'(dwr_cnt - bd), 64'd3);
    reset = 1'b1;
    #1;
    check_eq("mid_reset_outputs", out_bundle(), 64'd0);
    bs = swr_cnt; bd = dwr_cnt;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("post_reset_writes", 64'((swr_cnt - bs) + (dwr_cnt - bd)), 64'd0);
    check_eq("post_reset_idle", 64'({done, busy}), 64'd0);
    scen_plain(1'b1, "rerun");

    check_eq("wren_exclusive", 64'(overlap_cnt), 64'd0);
    check_eq("rdf_addr_all", 64'(rdf_bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
